// File: rtl/sr_ff_bank_param.sv
// Bank of WIDTH posedge flip-flops with a shared SR/JK/D/T mode and per-bit enables.
// SR illegal inputs (S=R=1) resolve by INV_POLICY and are logged in sticky flags and a saturating counter.
module sr_ff_bank_param #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter int               INV_POLICY = 0,
  parameter int               CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_any
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  // Out-of-range policies fall back to hold.
  localparam int INV_EFF = (INV_POLICY >= 0 && INV_POLICY <= 2) ? INV_POLICY : 0;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  function automatic logic resolve_sr_illegal(input logic qv);
    logic r;
    case (INV_EFF)
      1:       r = 1'b1;
      2:       r = 1'b0;
      default: r = qv;
    endcase
    return r;
  endfunction

  function automatic logic next_bit(input logic [1:0] m, input logic qv,
                                    input logic av, input logic bv);
    logic r;
    r = qv;
    case (m)
      MODE_SR: begin
        case ({av, bv})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = resolve_sr_illegal(qv);
          default: r = qv;
        endcase
      end
      MODE_JK: begin
        case ({av, bv})
          2'b01:   r = 1'b0;
          2'b10:   r = 1'b1;
          2'b11:   r = ~qv;
          default: r = qv;
        endcase
      end
      MODE_D:  r = av;
      MODE_T:  r = av ? ~qv : qv;
      default: r = qv;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_ONE;
  endfunction

  logic [WIDTH-1:0] q_p1;
  logic [WIDTH-1:0] flag_p1;
  logic [CNT_W-1:0] cnt_p1;

  logic [WIDTH-1:0] nxt_q_p0;
  logic [WIDTH-1:0] illegal_p0;

  // Stage p0: per-channel next state and illegal-SR detection
  always_comb begin
    nxt_q_p0   = q_p1;
    illegal_p0 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        nxt_q_p0[i] = next_bit(mode, q_p1[i], a[i], b[i]);
      end
      illegal_p0[i] = (mode == MODE_SR) && en[i] && a[i] && b[i];
    end
  end

  // Stage p1: state, sticky flags and event counter; a same-cycle event beats err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      q_p1    <= RST_VAL;
      flag_p1 <= '0;
      cnt_p1  <= CNT_ZERO;
    end else begin
      q_p1 <= nxt_q_p0;
      if (err_clr) begin
        flag_p1 <= illegal_p0;
        cnt_p1  <= (|illegal_p0) ? CNT_ONE : CNT_ZERO;
      end else begin
        flag_p1 <= flag_p1 | illegal_p0;
        if (|illegal_p0) begin
          cnt_p1 <= sat_inc(cnt_p1);
        end
      end
    end
  end

  assign q        = q_p1;
  assign qbar     = ~q_p1;
  assign err_flag = flag_p1;
  assign err_cnt  = cnt_p1;
  assign err_any  = |flag_p1;

endmodule
